serial_sub_ctrl: RTL and testbench

//  Bit-serial multi-bit subtractor controller that sequences one full-subtractor cell over WIDTH cycles.
//  It computes a - b - bin LSB-first, keeping the borrow in a register between bit positions.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/serial_sub_ctrl_fs_bit_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 118 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sub_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_bit_cell.sv
// One-bit full subtractor: d = x - y - z, bo = borrow out of this bit position.
module fs_bit_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (y & z) | (~x & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin controller: one fs_bit_cell reused over WIDTH cycles, LSB first.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start; diff/bout hold the last result
// S_RUN  | one bit per cycle through the cell, borrow carried in borrow_q
// S_DONE | one-cycle done pulse; a new start here is accepted back-to-back
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, diff_q, res_next;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q, bout_q;
    logic             cell_d, cell_bo;
    logic             accept, last_bit;

    fs_bit_cell u_cell (
        .x  (a_q[cnt_q]),
        .y  (b_q[cnt_q]),
        .z  (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_bit = (cnt_q == LAST_BIT);
    assign res_next = {cell_d, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Result registers load on the edge entering S_DONE, so diff/bout are
    // already valid while done is high and stay put until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
        end else if (state_q == S_RUN) begin
            acc_q    <= res_next;
            borrow_q <= cell_bo;
            if (!last_bit) cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
                diff_q <= res_next;
                bout_q <= cell_bo;
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!accept && state_q == S_RUN && last_bit) begin
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_d != a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8 against a subtract model.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
    logic         ovf_s;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf_s)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_s = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Launch one operation from a non-RUN cycle (~#1 after an edge) and wait for done.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bi_n,
                          output int lat, output int busy_cycles);
        start = 1'b1; a = ai; b = bi; bin = bi_n;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; bin = $urandom;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic bi_n);
        logic [W:0]   full;
        logic [W-1:0] ed;
        logic         eovf;
        full = {1'b0, ai} - {1'b0, bi} - {{W{1'b0}}, bi_n};
        ed   = full[W-1:0];
        eovf = (ai[W-1] != bi[W-1]) && (ed[W-1] != ai[W-1]);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(full[W]));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf_s), 32'(eovf));
`else
        if (eovf) begin end
`endif
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo, ov;
    } vec_t;

    vec_t vecs[5];
    int   lat, bc, gap, done_seen;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
        chk("rst_ovf",  32'(ovf_s), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bc);
            chk($sformatf("v%0d_lat", i),  32'(lat), 8);
            chk($sformatf("v%0d_busy", i), 32'(bc), 8);
            chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].d));
            chk($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("v%0d_ovf", i), 32'(ovf_s), 32'(vecs[i].ov));
`endif
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            chk($sformatf("v%0d_hold", i), 32'(diff), 32'(vecs[i].d));
        end

        // Start mid-RUN is ignored; start held in DONE is accepted back-to-back.
        start = 1'b1; a = 8'h20; b = 8'h03; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; a = 8'h99; b = 8'h11; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("midrun_lat", 32'(lat), 4);
        chk("midrun_diff", 32'(diff), 32'h1D);
        chk("midrun_bout", 32'(bout), 0);
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        while (!done && gap < 20) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b_gap", 32'(gap), 9);
        chk("b2b_diff", 32'(diff), 32'h0F);
        chk("b2b_bout", 32'(bout), 0);
        @(posedge clk); #1;

        // Reset in the 4th RUN cycle aborts with no done pulse.
        start = 1'b1; a = 8'h44; b = 8'h11; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_bout", 32'(bout), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 0);
        run_op(8'hAA, 8'h55, 1'b0, lat, bc);
        chk("post_rst_lat", 32'(lat), 8);
        chk("post_rst_diff", 32'(diff), 32'h55);
        chk("post_rst_bout", 32'(bout), 0);
        @(posedge clk); #1;

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] ra, rb;
            logic         rbi;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rbi = 1'($urandom);
            run_op(ra, rb, rbi, lat, bc);
            chk("rnd_lat", 32'(lat), 8);
            check_result("rnd", ra, rb, rbi);
            if (k[0]) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
